// File: rtl/div_pkg.sv
// Shared types and helpers for the divider front end.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        SETTLE,
        WAIT,
        RESP
    } div_arb_state_t;

    function automatic int idx_w(input int nr);
        return (nr > 1) ? $clog2(nr) : 1;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin grant picker: first set request strictly after the pointer, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is taken.
module rr_arb
    import div_pkg::*;
#(
    parameter  int NR = 3,
    localparam int IW = idx_w(NR)
) (
    input  logic [NR-1:0] req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [NR-1:0] gnt_o,
    output logic [IW-1:0] gnt_idx_o
);

    logic found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        // Upper half above the pointer first, then wrap to the lowest index.
        for (int i = 0; i < NR; i++) begin
            if (!found && req_i[i] && (i > int'(ptr_i))) begin
                found     = 1'b1;
                gnt_o[i]  = 1'b1;
                gnt_idx_o = IW'(i);
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (!found && req_i[i]) begin
                found     = 1'b1;
                gnt_o[i]  = 1'b1;
                gnt_idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/div_arb.sv
// Round-robin front end sharing one iterative divider; DIV_ARB_DZ_BYPASS_EN answers d==0 locally.
// Latency: accept to rsp_valid is divider latency + 3 cycles (1 cycle for a bypassed d==0).
// Backpressure: one operation in flight; req_ready stays low until the response handshakes.
module div_arb
    import div_pkg::*;
#(
    parameter  int DW = 8,
    parameter  int NR = 3,
    localparam int IW = idx_w(NR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NR-1:0]    req_valid,
    output logic [NR-1:0]    req_ready,
    input  logic [NR*DW-1:0] req_n,
    input  logic [NR*DW-1:0] req_d,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IW-1:0]    rsp_id,
    output logic [DW-1:0]    rsp_q,
    output logic [DW-1:0]    rsp_r,
    output logic             rsp_dz,
    output logic             busy,
    output logic             div_start,
    input  logic             div_ready,
    output logic [DW-1:0]    div_n,
    output logic [DW-1:0]    div_d,
    input  logic [DW-1:0]    div_q,
    input  logic [DW-1:0]    div_r
);

    div_arb_state_t state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [DW-1:0]  opn_q, opn_d;
    logic [DW-1:0]  opd_q, opd_d;
    logic [DW-1:0]  quo_q, quo_d;
    logic [DW-1:0]  rem_q, rem_d;
`ifdef DIV_ARB_DZ_BYPASS_EN
    logic           dz_q, dz_d;
`endif

    logic [NR-1:0]  gnt;
    logic [IW-1:0]  gnt_idx;
    logic [DW-1:0]  sel_n, sel_d;

    rr_arb #(.NR(NR)) u_rr (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        sel_n = '0;
        sel_d = '0;
        for (int i = 0; i < NR; i++) begin
            if (gnt[i]) begin
                sel_n = req_n[i*DW +: DW];
                sel_d = req_d[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        opn_d     = opn_q;
        opd_d     = opd_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
`ifdef DIV_ARB_DZ_BYPASS_EN
        dz_d      = dz_q;
`endif
        req_ready = '0;
        case (state_q)
            IDLE: begin
                req_ready = gnt;
                if (|(req_valid & gnt)) begin
                    ptr_d   = gnt_idx;
                    idx_d   = gnt_idx;
                    opn_d   = sel_n;
                    opd_d   = sel_d;
                    state_d = LAUNCH;
`ifdef DIV_ARB_DZ_BYPASS_EN
                    if (sel_d == '0) begin
                        quo_d   = '1;
                        rem_d   = sel_n;
                        dz_d    = 1'b1;
                        state_d = RESP;
                    end
`endif
                end
            end
            LAUNCH: state_d = SETTLE;
            // The divider may still show ready from the previous job here.
            SETTLE: state_d = WAIT;
            WAIT: begin
                if (div_ready) begin
                    quo_d   = div_q;
                    rem_d   = div_r;
`ifdef DIV_ARB_DZ_BYPASS_EN
                    dz_d    = 1'b0;
`endif
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IW'(NR - 1);
            idx_q   <= '0;
            opn_q   <= '0;
            opd_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
`ifdef DIV_ARB_DZ_BYPASS_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            opn_q   <= opn_d;
            opd_q   <= opd_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
`ifdef DIV_ARB_DZ_BYPASS_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign div_start = (state_q == LAUNCH);
    assign rsp_id    = idx_q;
    assign rsp_q     = quo_q;
    assign rsp_r     = rem_q;
    assign div_n     = opn_q;
    assign div_d     = opd_q;
`ifdef DIV_ARB_DZ_BYPASS_EN
    assign rsp_dz    = dz_q;
`else
    assign rsp_dz    = 1'b0;
`endif

endmodule

// File: tb/tb_div_arb.sv
// Bench for div_arb: bench-side divider model, per-cycle scoreboard and directed scenarios.
module tb_div_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [23:0] req_n, req_d;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_q, rsp_r;
    logic        rsp_dz, busy, div_start, div_ready;
    logic [7:0]  div_n, div_d, div_q, div_r;

    int tot = 0;
    int bad = 0;

    always #5 clk = ~clk;

    div_arb #(.DW(8), .NR(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n), .req_d(req_d),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dz(rsp_dz), .busy(busy),
        .div_start(div_start), .div_ready(div_ready), .div_n(div_n), .div_d(div_d),
        .div_q(div_q), .div_r(div_r)
    );

    // Divider model: result after dv_lat cycles, ready then stays high until the next start.
    int         dv_lat = 2;
    bit         dv_stale = 1'b0;
    int         dv_cnt;
    logic [7:0] pn, pd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            div_ready <= 1'b0; div_q <= '0; div_r <= '0; dv_cnt <= 0; pn <= '0; pd <= '0;
        end else if (div_start) begin
            dv_cnt    <= dv_lat;
            div_ready <= dv_stale & div_ready;
            pn        <= div_n;
            pd        <= div_d;
        end else if (dv_cnt > 1) begin
            dv_cnt    <= dv_cnt - 1;
            div_ready <= 1'b0;
        end else if (dv_cnt == 1) begin
            dv_cnt    <= 0;
            div_ready <= 1'b1;
            div_q     <= (pd == 0) ? 8'hFF : pn / pd;
            div_r     <= (pd == 0) ? pn : pn % pd;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [2:0] v, input int p);
        for (int k = 1; k <= 3; k++)
            if (((v >> ((p + k) % 3)) & 3'b001) != 0) return (p + k) % 3;
        return -1;
    endfunction

    // Transaction-level model: one job at a time, response due a fixed number of cycles after accept.
    int         m_ptr = 2;
    bit         m_job = 1'b0;
    bit         m_byp = 1'b0;
    int         m_age, m_id, m_rsp_age;
    logic [7:0] m_n, m_d, m_q, m_r, m_last_n, m_last_d;
    int         ds_cnt = 0;
    int         lg_id[$], lg_q[$], lg_r[$], lg_dz[$];

    always @(negedge clk) begin
        bit         e_vld;
        logic [2:0] e_rdy;
        int         g;
        if (rst) begin
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_div_start", div_start, 0);
            chk("rst_rsp_data", {rsp_id, rsp_q, rsp_r, rsp_dz}, 0);
            chk("rst_div_nd", {div_n, div_d}, 0);
            m_ptr = 2; m_job = 0; m_last_n = 0; m_last_d = 0;
        end else begin
            g     = rr_pick(req_valid, m_ptr);
            e_vld = m_job && (m_age >= m_rsp_age);
            e_rdy = (!m_job && g >= 0) ? (3'b001 << g) : 3'b000;
            chk("req_ready", req_ready, e_rdy);
            chk("busy", busy, m_job);
            chk("div_start", div_start, m_job && !m_byp && m_age == 1);
            chk("rsp_valid", rsp_valid, e_vld);
            chk("div_nd", {div_n, div_d}, {m_last_n, m_last_d});
            if (e_vld) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_qr", {rsp_q, rsp_r}, {m_q, m_r});
                chk("rsp_dz", rsp_dz, m_byp);
            end
            if (div_start) ds_cnt++;
            if (rsp_valid && rsp_ready) begin
                lg_id.push_back(rsp_id); lg_q.push_back(rsp_q);
                lg_r.push_back(rsp_r);   lg_dz.push_back(rsp_dz);
            end
            if (!m_job) begin
                if (g >= 0) begin
                    m_ptr = g; m_job = 1; m_age = 1; m_id = g;
                    m_n = 8'(req_n >> (g * 8));
                    m_d = 8'(req_d >> (g * 8));
                    m_last_n = m_n; m_last_d = m_d;
`ifdef DIV_ARB_DZ_BYPASS_EN
                    m_byp = (m_d == 0);
`else
                    m_byp = 1'b0;
`endif
                    m_q = (m_d == 0) ? 8'hFF : m_n / m_d;
                    m_r = (m_d == 0) ? m_n : m_n % m_d;
                    m_rsp_age = m_byp ? 1 : 3 + dv_lat;
                end
            end else if (e_vld && rsp_ready) begin
                m_job = 0;
            end else begin
                m_age++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [7:0] n, input logic [7:0] d);
        req_n[i*8 +: 8] = n;
        req_d[i*8 +: 8] = d;
    endtask

    task automatic wait_vld();
        int k = 0;
        while (!rsp_valid && k < 100) begin
            tick(1);
            k++;
        end
        chk("rsp_timeout", rsp_valid, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    int base, nrsp;
    int exp_id[4] = '{0, 1, 2, 0};
    int exp_q[4]  = '{10, 15, 0, 10};
    int exp_r[4]  = '{0, 15, 9, 0};

    initial begin
        req_valid = '0; req_n = '0; req_d = '0; rsp_ready = 1'b0;
        #1 rst = 1'b1;
        tick(2);
        chk("reset_busy", busy, 0);
        rst = 1'b0;

        // Single request, response held until rsp_ready.
        base = ds_cnt; dv_lat = 3;
        set_req(0, 100, 7); req_valid = 3'b001;
        #1 chk("t1_req_ready", req_ready, 3'b001);
        tick(1);
        req_valid = '0;
        chk("t1_div_start", div_start, 1);
        wait_vld();
        tick(3);
        chk("t1_rsp", {rsp_valid, 6'(rsp_id), rsp_q, rsp_r}, {1'b1, 6'd0, 8'd14, 8'd2});
        rsp_ready = 1'b1;
        tick(1);
        chk("t1_rsp_done", rsp_valid, 0);
        chk("t1_starts", ds_cnt - base, 1);

        // All three valid continuously: strict rotation.
        do_reset();
        base = ds_cnt; dv_lat = 2;
        lg_id.delete(); lg_q.delete(); lg_r.delete(); lg_dz.delete();
        set_req(0, 50, 5); set_req(1, 255, 16); set_req(2, 9, 10);
        req_valid = 3'b111;
        for (int k = 0; k < 200 && lg_q.size() < 4; k++) tick(1);
        req_valid = '0;
        tick(1);
        nrsp = lg_q.size();
        chk("t2_nrsp", nrsp, 4);
        for (int k = 0; k < 4 && k < nrsp; k++) begin
            chk("t2_id", lg_id[k], exp_id[k]);
            chk("t2_q", lg_q[k], exp_q[k]);
            chk("t2_r", lg_r[k], exp_r[k]);
        end
        chk("t2_starts", ds_cnt - base, 4);

        // Long response stall with requester 1 waiting.
        rsp_ready = 1'b0; dv_lat = 1;
        set_req(0, 60, 7); req_valid = 3'b001;
        tick(1);
        set_req(1, 90, 9); req_valid = 3'b010;
        wait_vld();
        for (int k = 0; k < 20; k++) begin
            chk("t3_hold", {rsp_valid, rsp_q, rsp_r}, {1'b1, 8'd8, 8'd4});
            chk("t3_req_ready", req_ready, 0);
            tick(1);
        end
        rsp_ready = 1'b1;
        tick(1);
        chk("t3_grant1", req_ready, 3'b010);
        tick(1);
        req_valid = '0;
        wait_vld();
        chk("t3_rsp1", {6'(rsp_id), rsp_q, rsp_r}, {6'd1, 8'd10, 8'd0});
        tick(1);

        // Stale ready from the previous job during SETTLE.
        dv_lat = 2; dv_stale = 1'b1;
        set_req(2, 200, 3); req_valid = 3'b100;
        tick(1);
        req_valid = '0;
        wait_vld();
        chk("t4_rsp", {6'(rsp_id), rsp_q, rsp_r}, {6'd2, 8'd66, 8'd2});
        tick(1);
        dv_stale = 1'b0;

        // Reset while waiting on the divider.
        dv_lat = 6;
        set_req(1, 77, 4); req_valid = 3'b010;
        tick(1);
        req_valid = '0;
        tick(3);
        chk("t5_in_wait", {busy, div_start, rsp_valid}, 3'b100);
        rst = 1'b1;
        #1;
        chk("t5_async", {rsp_valid, busy, div_start, req_ready}, 0);
        chk("t5_div_nd", {div_n, div_d}, 0);
        tick(1);
        rst = 1'b0;
        nrsp = 0;
        for (int k = 0; k < 12; k++) begin
            if (rsp_valid) nrsp++;
            tick(1);
        end
        chk("t5_no_rsp", nrsp, 0);
        set_req(0, 8, 2); req_valid = 3'b001;
        tick(1);
        req_valid = '0;
        wait_vld();
        chk("t5_rsp", {6'(rsp_id), rsp_q, rsp_r}, {6'd0, 8'd4, 8'd0});
        tick(1);

        // Divide by zero.
        base = ds_cnt; dv_lat = 2;
        set_req(2, 37, 0); req_valid = 3'b100;
        tick(1);
        req_valid = '0;
`ifdef DIV_ARB_DZ_BYPASS_EN
        chk("t6_rsp", {rsp_valid, rsp_q, rsp_r, rsp_dz}, {1'b1, 8'hFF, 8'd37, 1'b1});
        tick(1);
        chk("t6_starts", ds_cnt - base, 0);
`else
        wait_vld();
        chk("t6_rsp", {rsp_q, rsp_r, rsp_dz}, {8'hFF, 8'd37, 1'b0});
        tick(1);
        chk("t6_starts", ds_cnt - base, 1);
`endif
        tick(2);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
